// File: rtl/switch_sel_arbiter.sv
// Round-robin select generator for a 3-way a/b/c switch mux with bounded bursts.
// Optional SWITCH_SEL_ARB_LOCK_EN adds a lock input that extends a burst past expiry.
module switch_sel_arbiter #(
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req,
`ifdef SWITCH_SEL_ARB_LOCK_EN
   input  logic       lock,
`endif
   output logic [2:0] sel,
   output logic [2:0] grant,
   output logic       busy,
   output logic       burst_done
);

   typedef enum logic {IDLE, GRANT} st_t;

   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BURST_LEN - 1);
   localparam logic [2:0]       SEL_IDLE   = 3'b011;

   st_t              st;
   logic [1:0]       cur;
   logic [1:0]       last;
   logic [CNT_W-1:0] cnt;
   logic             hold;
   logic             release_now;
   logic [2:0]       pick_idle;
   logic [2:0]       pick_next;

`ifdef SWITCH_SEL_ARB_LOCK_EN
   assign hold = lock;
`else
   assign hold = 1'b0;
`endif

   // Returns {found, index}; scans last+1, last+2, then last itself.
   function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
      logic [1:0] i1, i2;
      i1 = (l == 2'd2) ? 2'd0 : l + 2'd1;
      i2 = (i1 == 2'd2) ? 2'd0 : i1 + 2'd1;
      if (r[i1])     return {1'b1, i1};
      else if (r[i2]) return {1'b1, i2};
      else if (r[l])  return {1'b1, l};
      else            return 3'b000;
   endfunction

   assign release_now = !req[cur] || ((cnt == '0) && !hold);
   assign pick_idle   = rr_pick(req, last);
   assign pick_next   = rr_pick(req, cur);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st         <= IDLE;
         cur        <= 2'd0;
         last       <= 2'd2;
         cnt        <= '0;
         sel        <= SEL_IDLE;
         grant      <= 3'b000;
         busy       <= 1'b0;
         burst_done <= 1'b0;
      end else begin
         burst_done <= 1'b0;
         case (st)
            IDLE: begin
               if (pick_idle[2]) begin
                  st    <= GRANT;
                  cur   <= pick_idle[1:0];
                  cnt   <= CNT_RELOAD;
                  sel   <= {1'b0, pick_idle[1:0]};
                  grant <= 3'b001 << pick_idle[1:0];
                  busy  <= 1'b1;
               end
            end
            GRANT: begin
               if (release_now) begin
                  last       <= cur;
                  burst_done <= 1'b1;
                  // Hand over directly to the next requester: no idle bubble.
                  if (pick_next[2]) begin
                     cur   <= pick_next[1:0];
                     cnt   <= CNT_RELOAD;
                     sel   <= {1'b0, pick_next[1:0]};
                     grant <= 3'b001 << pick_next[1:0];
                  end else begin
                     st    <= IDLE;
                     sel   <= SEL_IDLE;
                     grant <= 3'b000;
                     busy  <= 1'b0;
                  end
               end else if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_switch_sel_arbiter.sv
// Directed bench for switch_sel_arbiter (BURST_LEN=4); lock scenario only when SWITCH_SEL_ARB_LOCK_EN is defined.
module tb_switch_sel_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] req;
`ifdef SWITCH_SEL_ARB_LOCK_EN
   logic       lock;
`endif
   logic [2:0] sel;
   logic [2:0] grant;
   logic       busy;
   logic       burst_done;

   int checks = 0;
   int errors = 0;

   switch_sel_arbiter #(.BURST_LEN(4), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
`ifdef SWITCH_SEL_ARB_LOCK_EN
      .lock       (lock),
`endif
      .sel        (sel),
      .grant      (grant),
      .busy       (busy),
      .burst_done (burst_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // sel code 3 means idle; otherwise owner index
   task automatic chk_out(input string tag, input logic [2:0] esel, input logic ebd);
      logic [2:0] eg;
      eg = (esel == 3'b011) ? 3'b000 : (3'b001 << esel[1:0]);
      chk({tag, ".sel"}, {29'd0, sel}, {29'd0, esel});
      chk({tag, ".grant"}, {29'd0, grant}, {29'd0, eg});
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, (esel != 3'b011)});
      chk({tag, ".bd"}, {31'd0, burst_done}, {31'd0, ebd});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 3'b000;
`ifdef SWITCH_SEL_ARB_LOCK_EN
      lock = 1'b0;
`endif
      @(negedge clk);
      chk_out("reset", 3'b011, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req = 3'b000;
`ifdef SWITCH_SEL_ARB_LOCK_EN
      lock = 1'b0;
`endif

      // all three requesting: a x4, b x4, c x4, a...
      do_reset();
      req = 3'b111;
      for (int e = 1; e <= 14; e++) begin
         @(negedge clk);
         chk_out($sformatf("rr%0d", e), {1'b0, 2'(((e - 1) / 4) % 3)},
                 (e > 1) && ((e - 1) % 4 == 0));
      end

      // single requester re-granted every burst
      do_reset();
      req = 3'b001;
      for (int e = 1; e <= 9; e++) begin
         @(negedge clk);
         chk_out($sformatf("solo%0d", e), 3'b000, (e > 1) && ((e - 1) % 4 == 0));
      end

      // b requests for two cycles then drops
      do_reset();
      req = 3'b010;
      @(negedge clk); chk_out("early1", 3'b001, 1'b0);
      @(negedge clk); chk_out("early2", 3'b001, 1'b0);
      req = 3'b000;
      @(negedge clk); chk_out("early3", 3'b011, 1'b1);
      @(negedge clk); chk_out("early4", 3'b011, 1'b0);

      // b arrives mid-burst, a drops: direct handover
      do_reset();
      req = 3'b001;
      @(negedge clk); chk_out("hand1", 3'b000, 1'b0);
      req = 3'b011;
      @(negedge clk); chk_out("hand2", 3'b000, 1'b0);
      req = 3'b010;
      @(negedge clk); chk_out("hand3", 3'b001, 1'b1);
      @(negedge clk); chk_out("hand4", 3'b001, 1'b0);

      // asynchronous reset in second cycle of a burst
      do_reset();
      req = 3'b010;
      @(negedge clk); chk_out("mid1", 3'b001, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1 chk_out("mid_rst", 3'b011, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      req = 3'b011;
      @(negedge clk); chk_out("post_rst1", 3'b000, 1'b0);
      @(negedge clk); chk_out("post_rst2", 3'b000, 1'b0);

`ifdef SWITCH_SEL_ARB_LOCK_EN
      do_reset();
      req  = 3'b011;
      lock = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         chk_out($sformatf("lock%0d", e), 3'b000, 1'b0);
      end
      lock = 1'b0;
      @(negedge clk); chk_out("unlock", 3'b001, 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
